// File: rtl/uvc_vfb_pkg.sv
// uvc_vfb_pkg: shared FSM state type and pixel-width default for the UVC staging FIFO
package uvc_vfb_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, STREAM} vfb_state_t;
  localparam int PIX_W_DEF = 24;
endpackage

// File: rtl/uvc_vfb_ram.sv
// uvc_vfb_ram: simple dual-port pixel RAM, one write port, one registered read port (BSRAM style)
module uvc_vfb_ram #(
  parameter int AW = 10,
  parameter int DW = 24
) (
  input  logic          usb_clk_w,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  // write port, storage is not reset
  always_ff @(posedge usb_clk_w)
    if (we) mem[waddr] <= wdata;
  // registered read port; it doubles as the FIFO output register, so it holds unless read or flushed
  always_ff @(posedge usb_clk_w or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/uvc_vfb_fifo.sv
// uvc_vfb_fifo: FWFT pixel FIFO feeding the UVC core, re-aligned to source SOF on vfb_vs (UVC_VFB_DROP_EN: drop-on-full mode)
module uvc_vfb_fifo
  import uvc_vfb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int PIX_W      = PIX_W_DEF
) (
  input  logic                  usb_clk_w,
  input  logic                  rst_n,
  input  logic [PIX_W-1:0]      src_data_i,
  input  logic                  src_valid_i,
  input  logic                  src_sof_i,
  output logic                  src_ready_o,
  output logic [PIX_W-1:0]      vfb_data_o,
  output logic                  vfb_rdy_o,
  input  logic                  vfb_re_i,
  input  logic                  vfb_vs_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  ovf_o
);
  localparam int AW = DEPTH_LOG2;
  vfb_state_t state;
  logic [AW:0] wr_ptr, rd_ptr, wr_nx, rd_nx;
  logic ov, ov_nx, full, full_nx, we, pop, pf;
  // head pointer is the RAM read pointer minus the pixel parked in the output register
  function automatic logic ptr_full(input logic [AW:0] w, input logic [AW:0] r, input logic v);
    logic [AW:0] h;
    h = r - {{AW{1'b0}}, v};
    return (w[AW] != h[AW]) && (w[AW-1:0] == h[AW-1:0]);
  endfunction
  assign full = ptr_full(wr_ptr, rd_ptr, ov);
  assign vfb_rdy_o = ov;
  assign level_o = wr_ptr - rd_ptr + {{AW{1'b0}}, ov};
  // next-state pointers; vfb_vs overrides every write, pop and prefetch
  always_comb begin
    pop = vfb_re_i && ov && !vfb_vs_i;
    we = !vfb_vs_i && src_valid_i && ((state == STREAM) ? !full : (state == SYNC) && src_sof_i);
    pf = !vfb_vs_i && (wr_ptr != rd_ptr) && (!ov || pop);
    wr_nx = vfb_vs_i ? '0 : wr_ptr + {{AW{1'b0}}, we};
    rd_nx = vfb_vs_i ? '0 : rd_ptr + {{AW{1'b0}}, pf};
    ov_nx = !vfb_vs_i && (pf || (ov && !pop));
    full_nx = ptr_full(wr_nx, rd_nx, ov_nx);
  end
  // pointer and output-register-valid state
  always_ff @(posedge usb_clk_w or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ov <= 1'b0;
    end else begin
      wr_ptr <= wr_nx;
      rd_ptr <= rd_nx;
      ov <= ov_nx;
    end
  // framing FSM with registered ready and overflow flags
  always_ff @(posedge usb_clk_w or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      src_ready_o <= 1'b1;
      ovf_o <= 1'b0;
    end else begin
      state <= vfb_vs_i ? SYNC : (state == SYNC && we) ? STREAM : state;
`ifdef UVC_VFB_DROP_EN
      src_ready_o <= 1'b1;
      ovf_o <= !vfb_vs_i && (ovf_o || (state == STREAM && src_valid_i && full));
`else
      src_ready_o <= !full_nx;
      ovf_o <= 1'b0;
`endif
    end
  uvc_vfb_ram #(.AW(AW), .DW(PIX_W)) u_ram (
    .usb_clk_w (usb_clk_w),
    .rst_n     (rst_n),
    .clr       (vfb_vs_i),
    .we        (we),
    .waddr     (wr_ptr[AW-1:0]),
    .wdata     (src_data_i),
    .re        (pf),
    .raddr     (rd_ptr[AW-1:0]),
    .rdata     (vfb_data_o)
  );
endmodule

// File: tb/tb_uvc_vfb_fifo.sv
// tb_uvc_vfb_fifo: directed vector table plus hand sequences for fill, streaming, flush (UVC_VFB_DROP_EN selects drop checks)
module tb_uvc_vfb_fifo;
  localparam int D = 4;
  localparam int W = 24;
  logic usb_clk_w = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] src_data_i = '0;
  logic src_valid_i = 1'b0, src_sof_i = 1'b0, src_ready_o;
  logic [W-1:0] vfb_data_o;
  logic vfb_rdy_o, vfb_re_i = 1'b0, vfb_vs_i = 1'b0;
  logic [D:0] level_o;
  logic ovf_o;
  int nvec = 0, nerr = 0;
  int acc, nxt, want, bub;
  bit seen;
  typedef struct {
    logic vs, valid, sof, re;
    logic [W-1:0] data;
    logic rdy, chk_d;
    logic [W-1:0] q;
    logic [D:0] lvl;
  } vec_t;
  vec_t tbl[15];
  always #5 usb_clk_w = ~usb_clk_w;
  uvc_vfb_fifo #(.DEPTH_LOG2(D), .PIX_W(W)) dut (
    .usb_clk_w   (usb_clk_w),
    .rst_n       (rst_n),
    .src_data_i  (src_data_i),
    .src_valid_i (src_valid_i),
    .src_sof_i   (src_sof_i),
    .src_ready_o (src_ready_o),
    .vfb_data_o  (vfb_data_o),
    .vfb_rdy_o   (vfb_rdy_o),
    .vfb_re_i    (vfb_re_i),
    .vfb_vs_i    (vfb_vs_i),
    .level_o     (level_o),
    .ovf_o       (ovf_o)
  );
  function automatic vec_t mk(input logic vs, valid, sof, re, input logic [W-1:0] d,
                              input logic rdy, chk_d, input logic [W-1:0] q, input logic [D:0] lvl);
    vec_t v;
    v.vs = vs; v.valid = valid; v.sof = sof; v.re = re; v.data = d;
    v.rdy = rdy; v.chk_d = chk_d; v.q = q; v.lvl = lvl;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask
  task automatic drv(input logic vs, valid, sof, re, input logic [W-1:0] d);
    vfb_vs_i = vs; src_valid_i = valid; src_sof_i = sof; vfb_re_i = re; src_data_i = d;
  endtask
  task automatic tick;
    @(posedge usb_clk_w);
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = mk(0, 1, 1, 0, 24'hAA, 0, 1, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 24'hBB, 0, 1, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0,      0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 24'h10, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 24'h11, 0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 1,      0, 1, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 2,      0, 1, 0, 1);
    tbl[7]  = mk(0, 1, 0, 0, 3,      1, 1, 1, 2);
    tbl[8]  = mk(0, 1, 0, 1, 4,      1, 1, 1, 3);
    tbl[9]  = mk(0, 0, 0, 1, 0,      1, 1, 2, 3);
    tbl[10] = mk(0, 0, 0, 1, 0,      1, 1, 3, 2);
    tbl[11] = mk(0, 0, 0, 1, 0,      1, 1, 4, 1);
    tbl[12] = mk(0, 0, 0, 0, 0,      0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 0,      0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0,      0, 0, 0, 0);
    #12;
    chk("rst ready", src_ready_o, 1);
    chk("rst rdy", vfb_rdy_o, 0);
    chk("rst data", vfb_data_o, 0);
    chk("rst level", level_o, 0);
    chk("rst ovf", ovf_o, 0);
    #11 rst_n = 1'b1;
    tick;
    for (int i = 0; i < 16; i++) begin
      drv(0, 1, i == 0, 0, W'(i + 1));
      chk("idle rdy", vfb_rdy_o, 0);
      chk("idle level", level_o, 0);
      chk("idle ready", src_ready_o, 1);
      tick;
    end
    for (int i = 0; i < 15; i++) begin
      drv(tbl[i].vs, tbl[i].valid, tbl[i].sof, tbl[i].re, tbl[i].data);
      chk($sformatf("tbl%0d rdy", i), vfb_rdy_o, tbl[i].rdy);
      chk($sformatf("tbl%0d level", i), level_o, tbl[i].lvl);
      chk($sformatf("tbl%0d ready", i), src_ready_o, 1);
      if (tbl[i].chk_d) chk($sformatf("tbl%0d data", i), vfb_data_o, tbl[i].q);
      tick;
    end
    drv(1, 0, 0, 0, 0);
    tick;
`ifdef UVC_VFB_DROP_EN
    for (int c = 0; c < 18; c++) begin
      drv(0, 1, c == 0, 0, W'(c + 1));
      chk("drop ready", src_ready_o, 1);
      tick;
    end
    drv(0, 0, 0, 0, 0);
    tick;
    chk("drop ovf", ovf_o, 1);
    chk("drop level", level_o, 16);
    for (int k = 1; k <= 16; k++) begin
      chk("drop rdy", vfb_rdy_o, 1);
      chk("drop data", vfb_data_o, k);
      drv(0, 0, 0, 1, 0);
      tick;
    end
    drv(0, 0, 0, 0, 0);
    chk("drop empty", vfb_rdy_o, 0);
    chk("drop ovf held", ovf_o, 1);
    drv(1, 0, 0, 0, 0);
    tick;
    drv(0, 0, 0, 0, 0);
    chk("drop ovf clr", ovf_o, 0);
    chk("drop level clr", level_o, 0);
`else
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      drv(0, 1, acc == 0, 0, W'(acc + 1));
      if (src_ready_o) acc++;
      tick;
    end
    chk("fill accepted", acc, 16);
    chk("fill level", level_o, 16);
    chk("fill ready", src_ready_o, 0);
    chk("fill rdy", vfb_rdy_o, 1);
    chk("fill head", vfb_data_o, 1);
    chk("fill ovf", ovf_o, 0);
    drv(0, 1, 0, 1, 17);
    tick;
    chk("pop ready", src_ready_o, 1);
    chk("pop level", level_o, 15);
    drv(0, 1, 0, 0, 17);
    tick;
    drv(0, 0, 0, 0, 0);
    chk("refill level", level_o, 16);
    chk("refill ready", src_ready_o, 0);
    for (int k = 2; k <= 17; k++) begin
      chk("drain rdy", vfb_rdy_o, 1);
      chk("drain data", vfb_data_o, k);
      drv(0, 0, 0, 1, 0);
      tick;
    end
    drv(0, 0, 0, 0, 0);
    chk("drain empty", vfb_rdy_o, 0);
    chk("drain level", level_o, 0);
`endif
    drv(1, 0, 0, 0, 0);
    tick;
    nxt = 1; want = 1; bub = 0; seen = 0;
    for (int c = 0; c < 1000; c++) begin
      if (vfb_rdy_o) begin
        chk("stream data", vfb_data_o, want);
        want++;
        seen = 1;
      end else if (seen) bub++;
      drv(0, 1, nxt == 1, 1, W'(nxt));
      if (src_ready_o) nxt++;
      tick;
    end
    chk("stream bubbles", bub, 0);
    chk("stream pops", want - 1, 998);
    drv(0, 0, 0, 1, 0);
    for (int c = 0; c < 10; c++) begin
      if (vfb_rdy_o) begin
        chk("tail data", vfb_data_o, want);
        want++;
      end
      tick;
    end
    chk("stream total", want, nxt);
    drv(1, 0, 0, 0, 0);
    tick;
    for (int c = 0; c < 9; c++) begin
      drv(0, 1, c == 0, 0, W'(24'h100 + c));
      tick;
    end
    drv(0, 0, 0, 0, 0);
    tick;
    chk("pre-vs level", level_o, 9);
    chk("pre-vs head", vfb_data_o, 24'h100);
    drv(1, 1, 1, 0, 24'h55);
    tick;
    drv(0, 1, 0, 0, 24'h66);
    chk("vs level", level_o, 0);
    chk("vs rdy", vfb_rdy_o, 0);
    chk("vs data", vfb_data_o, 0);
    tick;
    drv(0, 1, 0, 0, 24'h67);
    tick;
    chk("sync discard", level_o, 0);
    drv(0, 1, 1, 0, 24'h77);
    tick;
    drv(0, 0, 0, 0, 0);
    chk("resof level", level_o, 1);
    chk("resof rdy early", vfb_rdy_o, 0);
    tick;
    chk("resof rdy", vfb_rdy_o, 1);
    chk("resof data", vfb_data_o, 24'h77);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
